// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared constants and types for the instruction fetch stage.
//   ADDR_W        : PC / ROM address width
//   INST_W        : instruction width
//   RESET_PC      : first fetch address after reset
//   FIFO_DEPTH    : default skid FIFO depth
//   fetch_entry_t : one fetched instruction tagged with its address
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int ADDR_W     = 16;
    localparam int INST_W     = 24;
    localparam int FIFO_DEPTH = 2;
    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// DEPTH-entry circular buffer of fetch entries sitting between the ROM return
// path and the decode input. The head entry is visible combinationally so the
// core sees an instruction in the same cycle it becomes the oldest entry.
//
// Ports:
//   clk     : clock, all state on rising edge
//   reset   : asynchronous, active-low; clears pointers, count and storage
//   push    : write data_in at the tail
//   pop     : retire the head entry
//   flush   : discard all entries (wins over push/pop)
//   data_in : entry to write
//   count   : number of live entries (0..DEPTH)
//   head    : oldest entry
// -----------------------------------------------------------------------------
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = FIFO_DEPTH,
    parameter type entry_t = fetch_entry_t,
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  entry_t        data_in,
    output logic [CW-1:0] count,
    output entry_t        head
);

    localparam int PW = $clog2(DEPTH);

    entry_t        mem_reg [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;

    // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap
    // by natural overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            // Push and pop together (including on a full FIFO) leave the
            // occupancy unchanged.
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage is cleared on reset so the head reads as zero straight away.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (push && !flush) begin
            mem_reg[wr_ptr_reg] <= data_in;
        end
    end

    assign count = count_reg;
    assign head  = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage between a synchronous instruction ROM and the
// decode input. Generates the PC, drives the ROM address, captures returning
// ROM data into a skid FIFO and presents one PC-tagged instruction per cycle.
// Absorbs decode stalls and flushes on branch/jump redirects.
//
// Ports:
//   clk         : clock, all state on rising edge
//   reset       : asynchronous, active-low
//   stall       : core cannot accept an instruction this cycle
//   redirect    : taken branch/jump; flush and refetch from redirect_pc
//   redirect_pc : redirect target
//   rom_addr    : ROM address, sampled by the ROM at the next rising edge
//   rom_data    : ROM read data, valid the cycle after its address
//   instr       : instruction at the FIFO head
//   instr_pc    : address of instr
//   instr_valid : instr/instr_pc hold a live instruction
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int                ADDR_W   = fetch_pkg::ADDR_W,
    parameter int                INST_W   = fetch_pkg::INST_W,
    parameter int                DEPTH    = fetch_pkg::FIFO_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_data,
    output logic [INST_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid
);

    import fetch_pkg::*;

    // Local entry type so non-default widths still pack correctly.
    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    localparam int CW = $clog2(DEPTH) + 1;
    // One extra bit so count + inflight cannot overflow before the compare.
    localparam int OW = CW + 1;

    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] req_pc_reg;
    logic [ADDR_W-1:0] req_pc_next;
    logic              inflight_reg;
    logic              inflight_next;

    logic [CW-1:0]     count;
    entry_t            head;
    entry_t            push_entry;
    logic              pop;
    logic              push;
    logic              issue;
    logic [OW-1:0]     occupancy;

    assign instr_valid = (count != '0);
    assign pop         = instr_valid & ~stall & ~redirect;

    // A ROM return is only kept if no redirect is flushing this cycle.
    assign push        = inflight_reg & ~redirect;
    assign push_entry  = '{inst: rom_data, pc: req_pc_reg};

    // Slots that will be occupied after this edge, counting the request
    // already in flight. Issuing only while this is below DEPTH guarantees a
    // returning word always finds room in the FIFO. pop implies count >= 1,
    // so the subtraction never underflows.
    assign occupancy   = OW'(count) + OW'(inflight_reg) - OW'(pop);
    assign issue       = redirect | (occupancy < OW'(DEPTH));

    // The redirect target goes to the ROM in the same cycle, saving a cycle
    // of redirect penalty.
    assign rom_addr    = redirect ? redirect_pc : pc_reg;

    always_comb begin
        pc_next       = pc_reg;
        req_pc_next   = req_pc_reg;
        inflight_next = 1'b0;
        if (issue) begin
            inflight_next = 1'b1;
            req_pc_next   = rom_addr;
            pc_next       = rom_addr + ADDR_W'(1);   // wraps modulo 2^ADDR_W
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg       <= RESET_PC;
            req_pc_reg   <= '0;
            inflight_reg <= 1'b0;
        end else begin
            pc_reg       <= pc_next;
            req_pc_reg   <= req_pc_next;
            inflight_reg <= inflight_next;
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .flush   (redirect),
        .data_in (push_entry),
        .count   (count),
        .head    (head)
    );

    assign instr    = head.inst;
    assign instr_pc = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Scoreboarded bench: the driver keeps a queue of the PCs the core should
// consume in program order (sequential, restarted at every redirect/reset);
// a negedge monitor pops one entry per accepted instruction and compares.
// A second instance with RESET_PC=16'hFFFE checks address wrap-around.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] rom_addr;
    logic [23:0] rom_data;
    logic [23:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;

    logic        b_stall    = 1'b0;
    logic        b_redirect = 1'b0;
    logic [15:0] b_redirect_pc = 16'h0000;
    logic [15:0] b_rom_addr;
    logic [23:0] b_rom_data;
    logic [23:0] b_instr;
    logic [15:0] b_instr_pc;
    logic        b_instr_valid;

    fetch_unit #(
        .ADDR_W(16), .INST_W(24), .DEPTH(2), .RESET_PC(16'h0000)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .rom_addr(rom_addr), .rom_data(rom_data),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid)
    );

    fetch_unit #(
        .ADDR_W(16), .INST_W(24), .DEPTH(2), .RESET_PC(16'hFFFE)
    ) dut_wrap (
        .clk(clk), .reset(reset), .stall(b_stall), .redirect(b_redirect),
        .redirect_pc(b_redirect_pc), .rom_addr(b_rom_addr), .rom_data(b_rom_data),
        .instr(b_instr), .instr_pc(b_instr_pc), .instr_valid(b_instr_valid)
    );

    // Synchronous ROM models: mem[a] = a + 0x100000
    always @(posedge clk) begin
        rom_data   <= 24'h100000 + {8'h00, rom_addr};
        b_rom_data <= 24'h100000 + {8'h00, b_rom_addr};
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- reference model: expected program-order PC stream -------
    logic [15:0] exp_q[$];
    logic [15:0] next_push;

    task automatic refill();
        while (exp_q.size() < 16) begin
            exp_q.push_back(next_push);
            next_push = next_push + 16'h1;
        end
    endtask

    task automatic restart(input logic [15:0] start);
        exp_q.delete();
        next_push = start;
        refill();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        refill();
    endtask

    task automatic wait_pc(input logic [15:0] target, input string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (instr_valid && instr_pc == target) found = 1'b1;
            else step();
        end
        chk(name, {31'h0, found}, 32'h1);
    endtask

    // ---------------- monitor ------------------------------------------------
    initial begin
        logic        hold;
        logic [15:0] hold_pc;
        logic [23:0] hold_instr;
        logic [15:0] e;
        hold = 1'b0;
        hold_pc = '0;
        hold_instr = '0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("stall_hold_valid", {31'h0, instr_valid}, 32'h1);
                    chk("stall_hold_pc", {16'h0, instr_pc}, {16'h0, hold_pc});
                    chk("stall_hold_instr", {8'h0, instr}, {8'h0, hold_instr});
                end
                if (instr_valid && !stall && !redirect) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_empty actual pc=%0h required=none", instr_pc);
                    end else begin
                        e = exp_q.pop_front();
                        $display("accept pc=%04h instr=%06h expected_pc=%04h", instr_pc, instr, e);
                        chk("sb_pc", {16'h0, instr_pc}, {16'h0, e});
                        chk("sb_instr", {8'h0, instr}, 32'h100000 + {16'h0, e});
                    end
                end
                hold       = instr_valid && stall && !redirect;
                hold_pc    = instr_pc;
                hold_instr = instr;
            end
        end
    end

    // ---------------- wrap-around instance -----------------------------------
    logic [15:0] wrap_seq [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

    initial begin
        @(posedge reset);
        chk("wrap_first_addr", {16'h0, b_rom_addr}, 32'hFFFE);
        @(posedge clk); #1;
        chk("wrap_edge1_valid", {31'h0, b_instr_valid}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("wrap_valid", {31'h0, b_instr_valid}, 32'h1);
            chk("wrap_pc", {16'h0, b_instr_pc}, {16'h0, wrap_seq[k]});
            chk("wrap_instr", {8'h0, b_instr}, 32'h100000 + {16'h0, wrap_seq[k]});
        end
    end

    // ---------------- watchdog -------------------------------------------------
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- driver ---------------------------------------------------
    initial begin
        reset = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 16'h0000;
        next_push = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_instr", {8'h0, instr}, 32'h0);
        chk("rst_pc", {16'h0, instr_pc}, 32'h0);
        chk("rst_rom_addr", {16'h0, rom_addr}, 32'h0);

        // Release: first edge issues RESET_PC, valid after the second edge.
        reset = 1'b1;
        restart(16'h0000);
        step();
        chk("edge1_valid", {31'h0, instr_valid}, 32'h0);
        step();
        chk("edge2_valid", {31'h0, instr_valid}, 32'h1);
        chk("edge2_pc", {16'h0, instr_pc}, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("run_valid", {31'h0, instr_valid}, 32'h1);
            chk("run_pc", {16'h0, instr_pc}, k);
        end

        // Stall while instr_pc=3.
        stall = 1'b1;
        repeat (5) begin
            step();
            chk("stall_instr", {8'h0, instr}, 32'h100003);
        end
        stall = 1'b0;
        for (int k = 4; k <= 6; k++) begin
            step();
            chk("post_stall_valid", {31'h0, instr_valid}, 32'h1);
            chk("post_stall_pc", {16'h0, instr_pc}, k);
        end

        // Redirect while instr_pc=7. The target is issued in the redirect
        // cycle and appears two edges later.
        wait_pc(16'h0007, "wait_pc7");
        redirect = 1'b1;
        redirect_pc = 16'h0040;
        restart(16'h0040);
        #1;
        chk("redir_rom_addr", {16'h0, rom_addr}, 32'h40);
        step();
        redirect = 1'b0;
        chk("redir_gap_valid", {31'h0, instr_valid}, 32'h0);
        step();
        chk("redir_tgt_valid", {31'h0, instr_valid}, 32'h1);
        chk("redir_tgt_pc", {16'h0, instr_pc}, 32'h40);
        repeat (3) step();

        // Redirect and stall together, stall held afterwards.
        redirect = 1'b1;
        stall = 1'b1;
        redirect_pc = 16'h0040;
        restart(16'h0040);
        step();
        redirect = 1'b0;
        chk("rs_gap_valid", {31'h0, instr_valid}, 32'h0);
        repeat (4) begin
            step();
            chk("rs_hold_valid", {31'h0, instr_valid}, 32'h1);
            chk("rs_hold_pc", {16'h0, instr_pc}, 32'h40);
        end
        stall = 1'b0;

        // Randomised stall/redirect traffic.
        for (int n = 0; n < 300; n++) begin
            step();
            stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 24) == 0) begin
                redirect = 1'b1;
                redirect_pc = 16'($urandom);
                restart(redirect_pc);
                #1;
                chk("rand_redir_addr", {16'h0, rom_addr}, {16'h0, redirect_pc});
            end else begin
                redirect = 1'b0;
            end
        end
        step();
        stall = 1'b0;
        redirect = 1'b0;
        repeat (4) step();

        // Fill the FIFO under stall, then reset mid-cycle.
        stall = 1'b1;
        repeat (3) step();
        chk("full_valid", {31'h0, instr_valid}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("async_rst_instr", {8'h0, instr}, 32'h0);
        chk("async_rst_pc", {16'h0, instr_pc}, 32'h0);
        chk("async_rst_addr", {16'h0, rom_addr}, 32'h0);
        step();
        step();
        stall = 1'b0;
        reset = 1'b1;
        restart(16'h0000);
        step();
        chk("rerun_edge1_valid", {31'h0, instr_valid}, 32'h0);
        step();
        chk("rerun_valid", {31'h0, instr_valid}, 32'h1);
        chk("rerun_pc", {16'h0, instr_pc}, 32'h0);
        repeat (5) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
